controle_execucao: RTL
======================

// Module: controle_execucao
// PURPOSE
//  Execution controller upstream of the processor clock divider. Drives its
//  congela/halt inputs from board switches, a push button and the processor's
//  HLT decode. Modes: free run, single step (one divider tick per button
//  press) and halted. Consumes the divider's new_clock pulse to end each step.
// PARAMETERS
//  DEB_CYCLES  1000000  stable-sample count for button debounce (20 ms @ 50 MHz)
//  DEB_W       20       debounce counter width; must satisfy 2**DEB_W > DEB_CYCLES
// PORTS
//  clock_fpga   in   1   board clock; only clock in the block
//  reset_n      in   1   asynchronous, active-low reset
//  btn_n        in   1   raw push button, active-low, asynchronous to clock_fpga
//  sw_modo      in   1   0 = free run, 1 = single step; asynchronous switch
//  halt_instr   in   1   processor decoded HLT; synchronous, level
//  new_clock    in   1   one-cycle tick from the divider
//  congela      out  1   to divider: hold its counter at zero
//  halt         out  1   to divider: pause its counter
//  estado       out  2   current state code (for LEDs/debug)
//  step_count   out  16  ticks issued (see CONFIGURATION)
// BEHAVIOUR
//  - btn_n and sw_modo pass through 2-flop synchronisers. Debounced button
//    level changes only after the synced level differs from it for DEB_CYCLES
//    consecutive cycles; any bounce restarts the count. press = one-cycle
//    pulse on the debounced 1->0 transition of btn_n. sw_modo is not debounced.
//  - States (estado code):
//    RUN  (00): congela=0 halt=0. halt_instr -> HALTED; synced sw_modo=1 -> WAIT.
//    WAIT (01): congela=1 halt=0. press -> FIRE; synced sw_modo=0 -> RUN.
//    FIRE (10): congela=0 halt=0. new_clock -> WAIT; halt_instr -> HALTED.
//               sw_modo is ignored in FIRE; the step always completes.
//    HALTED (11): congela=0 halt=1. press -> WAIT if synced sw_modo=1, else RUN.
//  - Outputs are registered from the state: they change 1 cycle after the
//    transition condition is sampled.
//  - Priority in the same cycle: halt_instr > new_clock > press > sw_modo.
//  - A press in RUN or FIRE is discarded, not queued.
//  - new_clock in RUN, WAIT or HALTED does not change the state.
//  - Reset, including mid-step: state=RUN, congela=0, halt=0, estado=00,
//    step_count=0, debounced button level=1 (released), debounce counter=0,
//    synchroniser flops=1 for btn_n and 0 for sw_modo.
//  - No arithmetic overflow on the debounce counter; it saturates at DEB_CYCLES.
// CONFIGURATION
//  STEP_COUNT_EN defined:
//    - step_count increments by 1 on every new_clock sampled in RUN or FIRE.
//    - It wraps from 0xFFFF to 0x0000 and is cleared only by reset.
//  STEP_COUNT_EN undefined:
//    - step_count is constant 16'd0 and the counter is not synthesised.
// TESTING (DEB_CYCLES=4, DEB_W=3)
//  1. reset_n=0 with btn_n=0, sw_modo=1, then release reset
//     -> congela=0, halt=0, estado=00 while in reset;
//     -> estado=01 and congela=1 a few cycles after release.
//  2. sw_modo=1 with a clean press of btn_n held low for 10 cycles
//     -> estado=01->10; congela=0 until the injected new_clock;
//     -> back to 01 one cycle later; exactly one step counted.
//  3. btn_n toggling every 2 cycles for 20 cycles, then steady high
//     -> no press is generated; estado remains 01.
//  4. RUN with halt_instr=1 for 1 cycle
//     -> estado=11, halt=1;
//     -> a press with sw_modo=0 returns to 00 and halt=0.
//  5. halt_instr and new_clock both asserted in the same cycle in FIRE
//     -> HALTED wins; with STEP_COUNT_EN, step_count still increments by 1.
//  6. STEP_COUNT_EN defined, RUN with 65537 new_clock ticks
//     -> step_count=1 (wrapped);
//     -> with the macro undefined, step_count=0 throughout.

Source files
------------

// File: rtl/controle_execucao.sv
// rtl/controle_execucao.sv - run/step/halt execution controller feeding the clock divider (option: STEP_COUNT_EN)
module controle_execucao #(
  parameter int DEB_CYCLES = 1000000,
  parameter int DEB_W      = 20
) (
  input  logic        clock_fpga,
  input  logic        reset_n,
  input  logic        btn_n,
  input  logic        sw_modo,
  input  logic        halt_instr,
  input  logic        new_clock,
  output logic        congela,
  output logic        halt,
  output logic [1:0]  estado,
  output logic [15:0] step_count
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_WAIT   = 2'b01,
    ST_FIRE   = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  // Last count value before the debounced level is allowed to flip.
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic btn_meta_q, btn_sync_q;
  logic sw_meta_q, sw_sync_q;

  // Two-flop synchronisers; button idles released (1), switch idles free-run (0).
  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta_q <= 1'b1;
      btn_sync_q <= 1'b1;
      sw_meta_q  <= 1'b0;
      sw_sync_q  <= 1'b0;
    end else begin
      btn_meta_q <= btn_n;
      btn_sync_q <= btn_meta_q;
      sw_meta_q  <= sw_modo;
      sw_sync_q  <= sw_meta_q;
    end
  end

  logic             deb_level_q, deb_level_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             press;

  // Debounce: count consecutive samples that disagree with the held level; any agreement restarts.
  always_comb begin
    deb_level_d = deb_level_q;
    deb_cnt_d   = '0;
    if (btn_sync_q != deb_level_q) begin
      if (deb_cnt_q >= DEB_LAST) begin
        deb_level_d = btn_sync_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Press is the debounced falling edge of the active-low button.
  assign press = deb_level_q & ~deb_level_d;

  // Debounce state register.
  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      deb_level_q <= 1'b1;
      deb_cnt_q   <= '0;
    end else begin
      deb_level_q <= deb_level_d;
      deb_cnt_q   <= deb_cnt_d;
    end
  end

  state_t state_q, state_d;
  logic   congela_q, congela_d;
  logic   halt_q, halt_d;

  // State register plus registered divider controls.
  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_RUN;
      congela_q <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      congela_q <= congela_d;
      halt_q    <= halt_d;
    end
  end

  // Next state; branch order encodes halt_instr > new_clock > press > sw_modo.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (halt_instr)     state_d = ST_HALTED;
        else if (sw_sync_q) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (press)           state_d = ST_FIRE;
        else if (!sw_sync_q) state_d = ST_RUN;
      end
      ST_FIRE: begin
        if (halt_instr)     state_d = ST_HALTED;
        else if (new_clock) state_d = ST_WAIT;
      end
      ST_HALTED: begin
        if (press) state_d = sw_sync_q ? ST_WAIT : ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output decode from the next state so the registered outputs track state_q.
  always_comb begin
    congela_d = (state_d == ST_WAIT);
    halt_d    = (state_d == ST_HALTED);
  end

  assign congela = congela_q;
  assign halt    = halt_q;
  assign estado  = state_q;

`ifdef STEP_COUNT_EN
  logic [15:0] step_q;

  // Count divider ticks that actually advance the processor; wraps naturally.
  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      step_q <= 16'd0;
    end else if (new_clock && (state_q == ST_RUN || state_q == ST_FIRE)) begin
      step_q <= step_q + 16'd1;
    end
  end

  assign step_count = step_q;
`else
  assign step_count = 16'd0;
`endif

endmodule
